// File: rtl/fir_decim_sink.sv
// Decimating sink for the FIR output: keep-one (default) or block-averaging
// decimation into a show-ahead FIFO drained through a ready/valid port.
// Define FIR_DECIM_AVG_EN to build the averaging mode.
module fir_decim_sink #(
  parameter int DATA_W     = 16,
  parameter int DECIM      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic signed [DATA_W-1:0]        fir_in,
  input  logic                            fir_in_valid,
  output logic signed [DATA_W-1:0]        m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  input  logic                            clr_ovf
);

  localparam int PH_W  = $clog2(DECIM);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DECIM - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [PH_W-1:0]          phase;
  logic                     push;
  logic signed [DATA_W-1:0] push_data;
  logic                     pop;
  logic                     push_ok;
  logic                     drop;

  logic signed [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase <= '0;
    end else if (fir_in_valid) begin
      phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
    end
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int ACC_W = DATA_W + PH_W;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  // Width ACC_W holds the sum of DECIM full-scale samples without wrap.
  assign sum       = acc + ACC_W'(fir_in);
  assign push      = fir_in_valid && (phase == PH_LAST);
  assign push_data = DATA_W'(sum >>> PH_W);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc <= '0;
    end else if (fir_in_valid) begin
      acc <= (phase == PH_LAST) ? '0 : sum;
    end
  end
`else
  assign push      = fir_in_valid && (phase == '0);
  assign push_data = fir_in;
`endif

  // Handshake: a word transfers on any edge where m_valid && m_ready; m_valid
  // only falls after such a transfer and m_data holds while the sink stalls.
  assign m_valid = (fifo_level != '0);
  assign pop     = m_valid && m_ready;
  assign push_ok = push && ((fifo_level != LVL_FULL) || pop);
  assign drop    = push && !push_ok;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        fifo_level <= fifo_level + LVL_W'(1);
      end else if (!push_ok && pop) begin
        fifo_level <= fifo_level - LVL_W'(1);
      end
    end
  end

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_decim_sink.sv
// Directed bench for fir_decim_sink (DATA_W=16, DECIM=4, FIFO_DEPTH=4);
// expectations follow whichever decimation mode FIR_DECIM_AVG_EN selects.
module tb_fir_decim_sink;

  logic               sys_clk;
  logic               sys_rst;
  logic signed [15:0] fir_in;
  logic               fir_in_valid;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic [2:0]         fifo_level;
  logic               overflow;
  logic               clr_ovf;

  int checks = 0;
  int errors = 0;

`ifdef FIR_DECIM_AVG_EN
  localparam int PUSH_IDX = 3;
`else
  localparam int PUSH_IDX = 0;
`endif

  fir_decim_sink #(.DATA_W(16), .DECIM(4), .FIFO_DEPTH(4)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .fir_in       (fir_in),
    .fir_in_valid (fir_in_valid),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic signed [15:0] v);
    fir_in       = v;
    fir_in_valid = 1'b1;
    step();
    fir_in_valid = 1'b0;
  endtask

  task automatic idle();
    fir_in_valid = 1'b0;
    step();
  endtask

  // One full group of four equal samples; m_ready/clr_ovf are only raised on
  // the strobe that produces the push in the current build mode.
  task automatic group(input logic signed [15:0] v, input logic rdy_push,
                       input logic clr_push);
    for (int i = 0; i < 4; i++) begin
      m_ready = (i == PUSH_IDX) ? rdy_push : 1'b0;
      clr_ovf = (i == PUSH_IDX) ? clr_push : 1'b0;
      fir_in       = v;
      fir_in_valid = 1'b1;
      step();
    end
    fir_in_valid = 1'b0;
    m_ready      = 1'b0;
    clr_ovf      = 1'b0;
  endtask

  initial begin
    sys_rst      = 1'b1;
    fir_in       = 16'sd99;
    fir_in_valid = 1'b1;
    m_ready      = 1'b0;
    clr_ovf      = 1'b0;

    // Reset held with strobes active
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_level", fifo_level, 0);
      check("rst_overflow", overflow, 0);
    end
    sys_rst      = 1'b0;
    fir_in_valid = 1'b0;
    step();
    check("post_rst_level", fifo_level, 0);

    // Main decimation on consecutive strobes
    m_ready = 1'b1;
`ifdef FIR_DECIM_AVG_EN
    feed(1); feed(2); feed(3);
    check("avg_wait_valid", m_valid, 0);
    feed(4);
    check("avg1_valid", m_valid, 1);
    check("avg1_data", m_data, 2);
    feed(-1);
    check("avg1_popped", m_valid, 0);
    feed(-2); feed(-3); feed(-4);
    check("avg2_valid", m_valid, 1);
    check("avg2_data", m_data, -3);
    idle();
    check("avg2_popped", m_valid, 0);
`else
    feed(1);
    check("keep1_valid", m_valid, 1);
    check("keep1_data", m_data, 1);
    feed(2);
    check("keep2_popped", m_valid, 0);
    feed(3); feed(4);
    check("keep4_valid", m_valid, 0);
    feed(5);
    check("keep5_valid", m_valid, 1);
    check("keep5_data", m_data, 5);
    feed(6);
    check("keep6_popped", m_valid, 0);
    feed(7); feed(8);
    check("keep8_valid", m_valid, 0);
    idle();
`endif

    // Gapped strobes: phase must hold across idle cycles
`ifdef FIR_DECIM_AVG_EN
    feed(10); idle(); feed(20); idle(); feed(30); idle();
    check("gap_early_valid", m_valid, 0);
    feed(40);
    check("gap_avg_valid", m_valid, 1);
    check("gap_avg_data", m_data, 25);
    idle();
    feed(50);
    check("gap_50_valid", m_valid, 0);
`else
    feed(10);
    check("gap10_valid", m_valid, 1);
    check("gap10_data", m_data, 10);
    idle();
    check("gap10_popped", m_valid, 0);
    feed(20); idle(); feed(30); idle(); feed(40);
    check("gap40_valid", m_valid, 0);
    idle();
    feed(50);
    check("gap50_valid", m_valid, 1);
    check("gap50_data", m_data, 50);
`endif

    // Reset mid-group discards the partial group
    feed(7); feed(8);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    check("midrst_level", fifo_level, 0);
    check("midrst_valid", m_valid, 0);
`ifdef FIR_DECIM_AVG_EN
    feed(9); feed(10); feed(11);
    check("midrst_wait", m_valid, 0);
    feed(12);
    check("midrst_valid_out", m_valid, 1);
    check("midrst_data", m_data, 10);
`else
    feed(9);
    check("midrst_valid_out", m_valid, 1);
    check("midrst_data", m_data, 9);
    feed(10);
    check("midrst_10", m_valid, 0);
    feed(11); feed(12);
    check("midrst_12", m_valid, 0);
`endif
    idle();
    check("midrst_drained", m_valid, 0);

    // Overflow under full back-pressure
    m_ready = 1'b0;
    group(100, 1'b0, 1'b0);
    group(200, 1'b0, 1'b0);
    group(300, 1'b0, 1'b0);
    group(400, 1'b0, 1'b0);
    check("ovf_full_level", fifo_level, 4);
    check("ovf_not_yet", overflow, 0);
    group(500, 1'b0, 1'b0);
    check("ovf_level", fifo_level, 4);
    check("ovf_set", overflow, 1);
    group(600, 1'b0, 1'b1);
    check("ovf_drop_beats_clr", overflow, 1);
    check("ovf_head", m_data, 100);
    m_ready = 1'b1;
    step();
    check("drain1_data", m_data, 200);
    check("drain1_level", fifo_level, 3);
    step();
    check("drain2_data", m_data, 300);
    step();
    check("drain3_data", m_data, 400);
    check("drain3_level", fifo_level, 1);
    step();
    check("drain_empty_valid", m_valid, 0);
    check("drain_empty_data", m_data, 0);
    check("drain_ovf_sticky", overflow, 1);
    m_ready = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full FIFO with push and pop on the same edge
    group(11, 1'b0, 1'b0);
    group(22, 1'b0, 1'b0);
    group(33, 1'b0, 1'b0);
    group(44, 1'b0, 1'b0);
    group(55, 1'b1, 1'b0);
    check("fullpop_level", fifo_level, 4);
    check("fullpop_no_ovf", overflow, 0);
    check("fullpop_head", m_data, 22);
    m_ready = 1'b1;
    step();
    check("fullpop_d33", m_data, 33);
    step();
    check("fullpop_d44", m_data, 44);
    step();
    check("fullpop_d55", m_data, 55);
    step();
    check("fullpop_empty", m_valid, 0);
    check("fullpop_level0", fifo_level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_decim_sink.md
# fir_decim_sink

Downstream consumer of the low-pass FIR output stream. Takes one filtered sample per `fir_in_valid` strobe, decimates by `DECIM`, and buffers the decimated samples in a show-ahead FIFO. The FIFO drains through a ready/valid master port into the next stage, for example a packetiser or a host readout. The block turns the FIR's free-running strobe stream into a back-pressurable stream and flags any samples lost to back-pressure.

## Interface
Parameters:
- `DATA_W`, default 16: sample width, signed two's complement; must equal the FIR output width.
- `DECIM`, default 8: decimation ratio, 2..256, power of two.
- `FIFO_DEPTH`, default 16: FIFO entries, power of two, at least 2.

Ports:
- `sys_clk`, input, 1 bit: single clock; every register is on its rising edge.
- `sys_rst`, input, 1 bit: reset, synchronous and active-high.
- `fir_in`, input, `DATA_W` bits, signed: filtered sample.
- `fir_in_valid`, input, 1 bit: `fir_in` is valid this cycle; there is no back-pressure toward the FIR.
- `m_data`, output, `DATA_W` bits, signed: FIFO head sample.
- `m_valid`, output, 1 bit: FIFO not empty.
- `m_ready`, input, 1 bit: downstream accepts `m_data`.
- `fifo_level`, output, `$clog2(FIFO_DEPTH)+1` bits: current occupancy.
- `overflow`, output, 1 bit: sticky flag, set when a decimated sample is dropped.
- `clr_ovf`, input, 1 bit: clears `overflow`.

## Operation
- **Phase counter.**
  - `phase` runs 0..DECIM-1 and advances only on `fir_in_valid`; cycles with `fir_in_valid` low change nothing.
  - It wraps from DECIM-1 to 0.
- **Decimated-sample production.** The point at which a sample is produced depends on the build mode (see Configuration). Call it a "push".
- **Push acceptance.**
  - A push is accepted when `fifo_level < FIFO_DEPTH`, or when a pop happens in the same cycle.
  - Otherwise the sample is dropped and `overflow` is set.
- **Pop.**
  - A pop occurs when `m_valid && m_ready`.
  - The read pointer advances and `fifo_level` decrements, unless a push lands in the same cycle, in which case the level is unchanged.
- **Pointers.** Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`. Order is strict FIFO.
- **Output data.** `m_data` is the entry at the read pointer when `m_valid` is high, and is forced to 0 when `m_valid` is low.
- **Overflow flag.**
  - `clr_ovf` clears `overflow` on the next edge.
  - A drop in the same cycle as `clr_ovf` wins, so `overflow` stays 1.
- **Handshake rule.** `m_valid` never deasserts without a pop, and `m_data` is stable while `m_valid && !m_ready`.

## Timing
- **Reset values.** `sys_rst` high at an edge gives:
  - `phase`=0, accumulator=0
  - pointers=0, `fifo_level`=0
  - `m_valid`=0, `m_data`=0
  - `overflow`=0
- **Reset mid-group.**
  - Reset discards partial groups and all FIFO contents.
  - The first `fir_in_valid` after reset deasserts is phase 0.
- **Input-to-output latency.** The push is written at the edge ending the producing cycle, so `m_valid` and `m_data` are visible in the next cycle. Latency from the producing `fir_in_valid` to `m_valid` is 1 cycle.
- **Throughput.** The pop path sustains 1 word per cycle; the push rate is at most 1 per `DECIM` input strobes.
- **Full FIFO with simultaneous pop.** With `fifo_level == FIFO_DEPTH`, a simultaneous push and pop accepts the push, and the level stays at `FIFO_DEPTH`.
- **Empty FIFO with push.** When the FIFO is empty, a push gives `m_valid` 1 cycle later. There is no combinational bypass from `fir_in` to `m_data`.

## Configuration
- **Macro:** `FIR_DECIM_AVG_EN`.
- **Defined (averaging mode).**
  - A signed accumulator of `DATA_W+$clog2(DECIM)` bits sums the samples of phases 0..DECIM-1.
  - At phase DECIM-1 the block pushes `(acc + fir_in) >>> $clog2(DECIM)`: an arithmetic shift, rounding toward minus infinity, truncated to `DATA_W`.
  - On the same edge the accumulator reloads to 0.
- **Undefined (keep-one mode).**
  - The sample at phase 0 is pushed directly; samples at phases 1..DECIM-1 are discarded.
  - No accumulator is synthesised.

## Test plan
All scenarios use `DATA_W`=16, `DECIM`=4, `FIFO_DEPTH`=4.
- **Reset.** Hold `sys_rst` high for 3 cycles with `fir_in_valid`=1 -> `m_valid`=0, `m_data`=0, `fifo_level`=0, `overflow`=0 throughout.
- **Keep-one decimation.**
  - Stimulus: keep-one build, `m_ready`=1, `fir_in` = 1..8 on 8 consecutive valid cycles.
  - Response: `m` stream carries 1 then 5, each with `m_valid` 1 cycle after the source sample.
- **Averaging.**
  - Stimulus: `FIR_DECIM_AVG_EN` build, inputs 1,2,3,4 then -1,-2,-3,-4.
  - Response: outputs 2 then -3 (from -10 >>> 2), each 1 cycle after the 4th sample.
- **Gapped input.** Keep-one build, `fir_in_valid` alternating 1/0 with values 10,20,30,40,50 on the valid cycles -> outputs 10 then 50, and phase does not advance on the 0 cycles.
- **Overflow.**
  - Stimulus: `m_ready`=0, 5 full groups.
  - Response: `fifo_level`=4, `overflow`=1, 5th sample dropped.
  - Then raise `m_ready` -> the 4 oldest samples drain in order on back-to-back cycles.
  - Then pulse `clr_ovf` -> `overflow`=0.
- **Reset mid-group.** Keep-one build, `m_ready`=1: feed 7,8, pulse `sys_rst` for 1 cycle, then feed 9,10,11,12 -> the only output is 9.
